data_memory_bytelane: RTL
=========================

DATA_MEMORY_BYTELANE -- requirements
Module: data_memory_bytelane

Interface
REQ-001 Parameter ADDR_W, default 10, number of word-address bits; memory depth SHALL be 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7, extra cycles between request acceptance and response.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  valid with rsp_valid: misaligned, illegal size, or out-of-range access.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-018 On acceptance, the block SHALL latch we, size, signed, addr and wdata; later input changes have no effect.
REQ-019 On acceptance: WAIT_STATES=0 -> RESP; otherwise -> WAIT with a wait counter loaded to WAIT_STATES-1.
REQ-020 WAIT: the counter decrements each cycle; at 0 the FSM goes to RESP.
REQ-021 RESP: rsp_valid=1 for exactly one cycle, then IDLE; accepted-to-rsp_valid latency = WAIT_STATES+1 cycles.
REQ-022 A new request SHALL NOT be accepted in the RESP cycle, so back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-023 Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
REQ-024 Error when: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or any bit of addr[31:ADDR_W+2] is 1.
REQ-025 Erroring accesses SHALL NOT modify memory; the response carries rsp_err=1 and rsp_rdata=0.
REQ-026 Store byte: write only lane addr[1:0] with wdata[7:0]; store half: lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; store word: all four lanes; unselected lanes are preserved.
REQ-027 The memory write SHALL occur on the clock edge that leaves the RESP state, so a load accepted afterwards returns the new data.
REQ-028 Loads SHALL read the addressed word in the RESP cycle, extract the selected byte or halfword, and extend it per the latched signed bit; word loads ignore signed.
REQ-029 rsp_rdata and rsp_err SHALL be 0 in every cycle where rsp_valid=0.
REQ-030 req_ready SHALL depend only on state, not combinationally on req_valid.

Reset
REQ-031 While rst_n=0: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1 (the value seen once rst_n rises).
REQ-032 Reset asserted mid-operation SHALL abort the access immediately; a store aborted before its write edge SHALL NOT modify memory.
REQ-033 Memory array contents are not reset and are undefined until written.

Verification
REQ-034 WAIT_STATES=1: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_valid exactly 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-035 After REQ-034: store byte 0x5A at 0x13, then load word at 0x10 -> 0x5AADBEEF; signed byte load at 0x13 -> 0x0000005A; signed byte load at 0x12 -> 0xFFFFFFAD; unsigned byte load at 0x12 -> 0x000000AD.
REQ-036 Store half 0x8001 at 0x12 with word 0x5AADBEEF present -> word reads 0x8001BEEF; signed half load at 0x12 -> 0xFFFF8001.
REQ-037 Errors: half load at 0x11, word store at 0x12, size=11, and address 0x1000 with ADDR_W=10 -> each gives rsp_err=1, rdata=0, and no memory change.
REQ-038 WAIT_STATES=0 and 3: hold req_valid=1 continuously -> acceptances spaced 2 and 5 cycles apart respectively; req_ready low while busy.
REQ-039 Pull rst_n low during WAIT of a word store of 0x12345678 to 0x20 -> outputs zero at once, memory at 0x20 keeps its prior value, and the next request is accepted normally.

Source files
------------

// File: rtl/data_memory_bytelane_if.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane_if
// Request/response bus for data_memory_bytelane.
//   req_valid   master->slave  request present
//   req_ready   slave->master  block can accept a request this cycle
//   req_we      master->slave  1 = store, 0 = load
//   req_size    master->slave  00 byte, 01 half, 10 word, 11 illegal
//   req_signed  master->slave  load extension: 1 = sign, 0 = zero
//   req_addr    master->slave  byte address
//   req_wdata   master->slave  store data, right-aligned
//   rsp_valid   slave->master  one-cycle response strobe
//   rsp_rdata   slave->master  extended load result (0 for stores/errors)
//   rsp_err     slave->master  misaligned / illegal size / out-of-range
//   busy        slave->master  block is not idle
// -----------------------------------------------------------------------------
interface data_memory_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane
// Single-port 32-bit data memory with byte/half/word access, little-endian
// byte lanes, sign/zero extension on loads and a fixed number of wait states.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_memory_bytelane_if.slave (request/response signals)
// Parameters:
//   ADDR_W       word-address bits, depth = 2**ADDR_W words
//   WAIT_STATES  extra cycles between acceptance and response (0..7)
// -----------------------------------------------------------------------------
module data_memory_bytelane #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  data_memory_bytelane_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt;
  logic        accept;

  // Request fields captured at acceptance; the bus may change afterwards.
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              acc_err;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              mem_we;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  // Ready depends only on state, so acceptance is simply valid in IDLE.
  assign accept = bus.req_valid && (state == IDLE);

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ------------------------------------------------------- counter and latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= 3'd0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      wait_cnt   <= WAIT_LOAD;
      lat_we     <= bus.req_we;
      lat_size   <= bus.req_size;
      lat_signed <= bus.req_signed;
      lat_addr   <= bus.req_addr;
      lat_wdata  <= bus.req_wdata;
    end else if (state == WAIT && wait_cnt != 3'd0) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // -------------------------------------------------------------- next state
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves a value unassigned (no inferred latches).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 3'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------ access decode
  assign word_idx = lat_addr[ADDR_W+1:2];

  always_comb begin
    acc_err = 1'b0;
    case (lat_size)
      2'b00: acc_err = 1'b0;
      2'b01: acc_err = lat_addr[0];
      2'b10: acc_err = (lat_addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ((lat_addr >> (ADDR_W + 2)) != 32'd0) acc_err = 1'b1;
  end

  // Store data is replicated across lanes; the byte enables pick the lanes.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = lat_wdata;
    case (lat_size)
      2'b00: begin
        lane_be    = 4'b0001 << lat_addr[1:0];
        lane_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{lat_wdata[15:0]}};
      end
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
    if (acc_err) lane_be = 4'b0000;
  end

  // Write happens on the edge that leaves RESP; an async reset forces IDLE
  // first, so an aborted store never reaches this edge.
  assign mem_we = (state == RESP) && lat_we && !acc_err;

  // NOTE: the memory array has no reset; clearing it would turn the RAM
  // into flops and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------------ load path
  assign rd_word = mem[word_idx];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lat_addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  assign rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (lat_size)
      2'b00:   load_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{lat_signed & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = 32'd0;
    if (state == RESP) begin
      bus.rsp_err = acc_err;
      if (!acc_err && !lat_we) bus.rsp_rdata = load_data;
    end
  end

endmodule
